// File: rtl/dcache_pkg.sv
// Shared constants and FSM state encoding for the direct-mapped write-back data cache.
package dcache_pkg;

   localparam int DC_INDEX_WIDTH    = 8;
   localparam int DC_MEM_ADDR_WIDTH = 25;
   localparam int DC_SPACE_OFFSET   = 2;
   localparam int DC_TAG_WIDTH      = DC_MEM_ADDR_WIDTH - DC_INDEX_WIDTH;
   localparam int DC_LINE_NUM       = 1 << DC_INDEX_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WBACK  = 2'd1,
      REFILL = 2'd2
   } dc_state_t;

endpackage

// File: rtl/dcache_store.sv
// Line storage for the data cache: valid/dirty bits (cleared on reset) plus tag and data
// arrays that keep their contents across reset. Reads are asynchronous.
module dcache_store
   import dcache_pkg::*;
#(
   parameter int INDEX_WIDTH = DC_INDEX_WIDTH,
   parameter int TAG_WIDTH   = DC_TAG_WIDTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [INDEX_WIDTH-1:0] i_index,
   output logic                   o_valid,
   output logic                   o_dirty,
   output logic [TAG_WIDTH-1:0]   o_tag,
   output logic [31:0]            o_data,
   input  logic                   i_we,
   input  logic [TAG_WIDTH-1:0]   i_wtag,
   input  logic [31:0]            i_wdata,
   input  logic                   i_validSet,
   input  logic                   i_dirtySet,
   input  logic                   i_dirtyClr
);

   localparam int LINE_NUM = 1 << INDEX_WIDTH;

   logic [LINE_NUM-1:0]  r_validBits;
   logic [LINE_NUM-1:0]  r_dirtyBits;
   logic [TAG_WIDTH-1:0] r_tagArr  [LINE_NUM];
   logic [31:0]          r_dataArr [LINE_NUM];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_validBits <= '0;
         r_dirtyBits <= '0;
      end else begin
         if (i_validSet)
            r_validBits[i_index] <= 1'b1;
         if (i_dirtySet)
            r_dirtyBits[i_index] <= 1'b1;
         else if (i_dirtyClr)
            r_dirtyBits[i_index] <= 1'b0;
      end
   end

   // Tag and data are deliberately not reset; an invalid line's contents are never used.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_tagArr[i_index]  <= i_wtag;
         r_dataArr[i_index] <= i_wdata;
      end
   end

   assign o_valid = r_validBits[i_index];
   assign o_dirty = r_dirtyBits[i_index];
   assign o_tag   = r_tagArr[i_index];
   assign o_data  = r_dataArr[i_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with one-word lines.
// Define DCACHE_STATS_EN to add the o_hit_cnt / o_miss_cnt statistics outputs.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int INDEX_WIDTH    = DC_INDEX_WIDTH,
   parameter int MEM_ADDR_WIDTH = DC_MEM_ADDR_WIDTH,
   parameter int SPACE_OFFSET   = DC_SPACE_OFFSET
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cpu_r,
   input  logic        i_cpu_w,
   input  logic [31:0] i_cpu_addr,
   input  logic [31:0] i_cpu_wdata,
   output logic [31:0] o_cpu_rdata,
   output logic        o_cpu_ready,
   output logic        o_mem_r,
   output logic        o_mem_w,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_w_data,
   input  logic [31:0] i_mem_r_data,
   input  logic        i_mem_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] o_hit_cnt,
   output logic [31:0] o_miss_cnt
`endif
);

   localparam int TAG_WIDTH = MEM_ADDR_WIDTH - INDEX_WIDTH;

   dc_state_t r_state;
   dc_state_t w_nextState;

   logic [MEM_ADDR_WIDTH-1:0] w_wa;
   logic [INDEX_WIDTH-1:0]    w_index;
   logic [TAG_WIDTH-1:0]      w_tag;
   logic                      w_req;
   logic                      w_hit;

   logic                      w_lineValid;
   logic                      w_lineDirty;
   logic [TAG_WIDTH-1:0]      w_lineTag;
   logic [31:0]               w_lineData;

   logic                      w_we;
   logic [31:0]               w_wdata;
   logic                      w_validSet;
   logic                      w_dirtySet;
   logic                      w_dirtyClr;

   logic [MEM_ADDR_WIDTH-1:0] w_victimWa;
   logic                      w_unusedAddrBits;

   assign w_wa             = i_cpu_addr[MEM_ADDR_WIDTH+SPACE_OFFSET-1:SPACE_OFFSET];
   assign w_index          = w_wa[INDEX_WIDTH-1:0];
   assign w_tag            = w_wa[MEM_ADDR_WIDTH-1:INDEX_WIDTH];
   assign w_req            = i_cpu_r | i_cpu_w;
   assign w_hit            = w_lineValid && (w_lineTag == w_tag);
   assign w_victimWa       = {w_lineTag, w_index};
   assign w_unusedAddrBits = ^{i_cpu_addr[31:MEM_ADDR_WIDTH+SPACE_OFFSET], i_cpu_addr[SPACE_OFFSET-1:0]};

   dcache_store #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_WIDTH   (TAG_WIDTH)
   ) u_store (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_index    (w_index),
      .o_valid    (w_lineValid),
      .o_dirty    (w_lineDirty),
      .o_tag      (w_lineTag),
      .o_data     (w_lineData),
      .i_we       (w_we),
      .i_wtag     (w_tag),
      .i_wdata    (w_wdata),
      .i_validSet (w_validSet),
      .i_dirtySet (w_dirtySet),
      .i_dirtyClr (w_dirtyClr)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   // Memory requests drop in the ready cycle so the memory is never re-armed by a stale request.
   always_comb begin
      w_nextState  = r_state;
      o_cpu_ready  = 1'b0;
      o_cpu_rdata  = 32'd0;
      o_mem_r      = 1'b0;
      o_mem_w      = 1'b0;
      o_mem_addr   = 32'd0;
      o_mem_w_data = 32'd0;
      w_we         = 1'b0;
      w_wdata      = i_cpu_wdata;
      w_validSet   = 1'b0;
      w_dirtySet   = 1'b0;
      w_dirtyClr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               if (w_hit) begin
                  o_cpu_ready = 1'b1;
                  if (i_cpu_w) begin
                     w_we       = 1'b1;
                     w_dirtySet = 1'b1;
                  end else begin
                     o_cpu_rdata = w_lineData;
                  end
               end else if (w_lineValid && w_lineDirty) begin
                  w_nextState = WBACK;
               end else begin
                  w_nextState = REFILL;
               end
            end
         end
         WBACK: begin
            o_mem_w      = !i_mem_ready;
            o_mem_addr   = 32'(w_victimWa) << SPACE_OFFSET;
            o_mem_w_data = w_lineData;
            if (i_mem_ready) begin
               w_dirtyClr  = 1'b1;
               w_nextState = REFILL;
            end
         end
         REFILL: begin
            o_mem_r    = !i_mem_ready;
            o_mem_addr = 32'(w_wa) << SPACE_OFFSET;
            if (i_mem_ready) begin
               w_we        = 1'b1;
               w_wdata     = i_mem_r_data;
               w_validSet  = 1'b1;
               w_dirtyClr  = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic        r_missed;
   logic [31:0] r_hitCnt;
   logic [31:0] r_missCnt;

   // A missed request later completes as a retried hit; r_missed keeps it out of the hit count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_missed  <= 1'b0;
         r_hitCnt  <= 32'd0;
         r_missCnt <= 32'd0;
      end else begin
         if (r_state == IDLE && w_nextState != IDLE) begin
            r_missCnt <= r_missCnt + 32'd1;
            r_missed  <= 1'b1;
         end
         if (o_cpu_ready) begin
            r_missed <= 1'b0;
            if (!r_missed)
               r_hitCnt <= r_hitCnt + 32'd1;
         end
      end
   end

   assign o_hit_cnt  = r_hitCnt;
   assign o_miss_cnt = r_missCnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized scoreboard bench for dcache_ctrl against a transparent-memory reference model,
// with a 4-count latency memory attached.
module tb_dcache_ctrl;

   localparam int MEM_CNT_MAX = 4;
   localparam int LAT_CLEAN   = 7;
   localparam int LAT_DIRTY   = 13;

   typedef struct {
      bit          isRead;
      logic [31:0] expData;
      int          expLat;
      int          startCycle;
   } sb_t;

   logic        clk;
   logic        rst;
   logic        cpu_r;
   logic        cpu_w;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_r;
   logic        mem_w;
   logic [31:0] mem_addr;
   logic [31:0] mem_w_data;
   logic [31:0] mem_r_data;
   logic        mem_ready;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;
   int memCnt   = 0;
   bit reqDone  = 0;
   bit memWSeen = 0;
   sb_t sbQ[$];
   sb_t monEntry;

   logic [31:0] tbMem   [int unsigned];
   logic [31:0] refMem  [int unsigned];
   logic [31:0] visible [int unsigned];
   bit          cValid [256];
   bit          cDirty [256];
   int unsigned cWord  [256];
   int          hitCount  = 0;
   int          missCount = 0;

   dcache_ctrl dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_cpu_r      (cpu_r),
      .i_cpu_w      (cpu_w),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_wdata  (cpu_wdata),
      .o_cpu_rdata  (cpu_rdata),
      .o_cpu_ready  (cpu_ready),
      .o_mem_r      (mem_r),
      .o_mem_w      (mem_w),
      .o_mem_addr   (mem_addr),
      .o_mem_w_data (mem_w_data),
      .i_mem_r_data (mem_r_data),
      .i_mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
      ,
      .o_hit_cnt    (hit_cnt),
      .o_miss_cnt   (miss_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [31:0] initWord(input int unsigned wa);
      return (wa * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   function automatic logic [31:0] memRead(input int unsigned wa);
      if (tbMem.exists(wa)) return tbMem[wa];
      return initWord(wa);
   endfunction

   function automatic logic [31:0] refRead(input int unsigned wa);
      if (refMem.exists(wa)) return refMem[wa];
      return initWord(wa);
   endfunction

   function automatic logic [31:0] visRead(input int unsigned wa);
      if (visible.exists(wa)) return visible[wa];
      return refRead(wa);
   endfunction

   // Word memory: a request is accepted after MEM_CNT_MAX+1 cycles, then mem_ready pulses once.
   always @(posedge clk) begin : memModel
      int unsigned mwa;
      if (rst) begin
         memCnt    <= 0;
         mem_ready <= 1'b0;
      end else begin
         mem_ready  <= 1'b0;
         mem_r_data <= $urandom;
         if ((mem_r || mem_w) && !mem_ready) begin
            if (memCnt == MEM_CNT_MAX) begin
               memCnt    <= 0;
               mem_ready <= 1'b1;
               mwa = int'(mem_addr[26:2]);
               if (mem_w)
                  tbMem[mwa] = mem_w_data;
               else
                  mem_r_data <= memRead(mwa);
            end else begin
               memCnt <= memCnt + 1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Monitor: protocol checks every cycle, scoreboard pop whenever the DUT completes a request.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_r || mem_w) begin
            checkOutput("mem_rw_exclusive", {31'd0, mem_r & mem_w}, 32'd0);
            checkOutput("mem_addr_format", {25'd0, mem_addr[31:27], mem_addr[1:0]}, 32'd0);
            if (mem_w) memWSeen = 1'b1;
         end
         if ((cpu_r || cpu_w) && !(cpu_ready && cpu_r))
            checkOutput("rdata_zero", cpu_rdata, 32'd0);
         if (cpu_ready) begin
            if (sbQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_ready: got cpu_ready=1, expected no pending request");
            end else begin
               monEntry = sbQ.pop_front();
               checkOutput("latency", 32'(cycle - monEntry.startCycle), 32'(monEntry.expLat));
               if (monEntry.isRead)
                  checkOutput("load_data", cpu_rdata, monEntry.expData);
               reqDone = 1'b1;
            end
         end
      end
   end

   task automatic modelReset();
      for (int i = 0; i < 256; i++) begin
         if (cValid[i] && cDirty[i]) visible.delete(cWord[i]);
         cValid[i] = 1'b0;
         cDirty[i] = 1'b0;
      end
      hitCount  = 0;
      missCount = 0;
   endtask

   task automatic doReset();
      rst   = 1'b1;
      cpu_r = 1'b0;
      cpu_w = 1'b0;
      sbQ.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that completes the request.
   task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] wdata);
      int unsigned wa;
      int unsigned idx;
      sb_t e;
      bit done;
      wa  = (addr >> 2) & 32'h01FF_FFFF;
      idx = wa & 32'd255;
      if (cValid[idx] && cWord[idx] == wa) begin
         e.expLat = 0;
         hitCount++;
      end else begin
         missCount++;
         if (cValid[idx] && cDirty[idx]) begin
            refMem[cWord[idx]] = visRead(cWord[idx]);
            e.expLat = LAT_DIRTY;
         end else begin
            e.expLat = LAT_CLEAN;
         end
         cValid[idx] = 1'b1;
         cDirty[idx] = 1'b0;
         cWord[idx]  = wa;
      end
      if (isWrite) begin
         visible[wa] = wdata;
         cDirty[idx] = 1'b1;
         e.isRead    = 1'b0;
         e.expData   = 32'd0;
      end else begin
         e.isRead  = 1'b1;
         e.expData = visRead(wa);
      end
      e.startCycle = cycle;
      reqDone = 1'b0;
      sbQ.push_back(e);
      cpu_addr  = addr;
      cpu_wdata = isWrite ? wdata : $urandom;
      cpu_r     = !isWrite;
      cpu_w     = isWrite;
      done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         if (reqDone) begin
            done = 1'b1;
            break;
         end
      end
      #1;
      cpu_r = 1'b0;
      cpu_w = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("[TB] FAIL request_timeout: got no cpu_ready in 100 cycles, expected latency %0d (addr 0x%08h)", e.expLat, addr);
         sbQ.delete();
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic [31:0] addr;
      int unsigned tag;
      int unsigned idx;
      cpu_addr  = 32'd0;
      cpu_wdata = 32'd0;
      rst       = 1'b1;
      cpu_r     = 1'b0;
      cpu_w     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
      @(negedge clk);
      checkOutput("reset_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      checkOutput("reset_cpu_rdata", cpu_rdata, 32'd0);
      checkOutput("reset_mem_r", {31'd0, mem_r}, 32'd0);
      checkOutput("reset_mem_w", {31'd0, mem_w}, 32'd0);
      checkOutput("reset_mem_addr", mem_addr, 32'd0);
      checkOutput("reset_mem_w_data", mem_w_data, 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] clean miss then hit on 0x100");
      applyStimulus(1'b0, 32'h0000_0100, 32'd0);
      applyStimulus(1'b0, 32'h0000_0100, 32'd0);

      $display("[TB] store hit and reload");
      memWSeen = 1'b0;
      applyStimulus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'h0000_0100, 32'd0);
      checkOutput("store_hit_no_mem_w", {31'd0, memWSeen}, 32'd0);

      $display("[TB] conflicting load forces write-back");
      applyStimulus(1'b0, 32'h0000_0500, 32'd0);
      checkOutput("wback_mem_0x40", memRead(32'h40), 32'hDEAD_BEEF);

      $display("[TB] store miss on a clean line");
      memWSeen = 1'b0;
      applyStimulus(1'b1, 32'h0000_0204, 32'h1234_5678);
      checkOutput("store_miss_no_mem_w", {31'd0, memWSeen}, 32'd0);
      applyStimulus(1'b0, 32'h0000_0204, 32'd0);

      $display("[TB] reset during refill");
      cpu_addr = 32'h0000_0308;
      cpu_r    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("refill_mem_r_active", {31'd0, mem_r}, 32'd1);
      rst   = 1'b1;
      cpu_r = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_mem_r_low", {31'd0, mem_r}, 32'd0);
      checkOutput("rst_mem_w_low", {31'd0, mem_w}, 32'd0);
      checkOutput("rst_cpu_ready_low", {31'd0, cpu_ready}, 32'd0);
      rst = 1'b0;
      modelReset();
      applyStimulus(1'b0, 32'h0000_0308, 32'd0);
      applyStimulus(1'b0, 32'h0000_0100, 32'd0);

      $display("[TB] statistics sequence");
      doReset();
      applyStimulus(1'b0, 32'h0000_0100, 32'd0);
      applyStimulus(1'b0, 32'h0000_0100, 32'd0);
      applyStimulus(1'b1, 32'h0000_0100, 32'hCAFE_F00D);
      applyStimulus(1'b0, 32'h0000_0800, 32'd0);
      applyStimulus(1'b0, 32'h0000_0800, 32'd0);
`ifdef DCACHE_STATS_EN
      @(negedge clk);
      checkOutput("stats_hit_cnt", hit_cnt, 32'd3);
      checkOutput("stats_miss_cnt", miss_cnt, 32'd2);
      @(posedge clk);
      #1;
`endif

      $display("[TB] randomized traffic");
      for (int n = 0; n < 300; n++) begin
         tag = $urandom_range(0, 3);
         idx = ($urandom_range(0, 4) == 4) ? 32'd255 : $urandom_range(0, 3);
         addr = (32'($urandom_range(0, 31)) << 27) | (((tag << 8) | idx) << 2) | 32'($urandom_range(0, 3));
         applyStimulus($urandom_range(0, 1) == 1, addr, $urandom);
      end

      @(negedge clk);
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
      foreach (refMem[w])
         checkOutput("final_mem", memRead(w), refMem[w]);
`ifdef DCACHE_STATS_EN
      checkOutput("final_hit_cnt", hit_cnt, 32'(hitCount));
      checkOutput("final_miss_cnt", miss_cnt, 32'(missCount));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
